reg_operand_fetch: RTL

//  Initiator for the 16x16 register file: drives its two read ports and its write port.

---
 rtl/reg_operand_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_operand_fetch.sv
// Operand-fetch/issue stage for a 16x16 register file: busy-register scoreboard, 1-cycle issue->op_valid,
// bundle held while op_ready=0. Optional BYPASS_EN macro forwards a same-cycle writeback to the sources.
module reg_operand_fetch #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [ADDR_W-1:0]        iss_rs1,
  input  logic [ADDR_W-1:0]        iss_rs2,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     iss_wr,
  output logic [ADDR_W-1:0]        read_add_1,
  output logic [ADDR_W-1:0]        read_add_2,
  input  logic [DATA_W-1:0]        read_data_1,
  input  logic [DATA_W-1:0]        read_data_2,
  output logic [ADDR_W-1:0]        wr_reg_add,
  output logic                     wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [ADDR_W-1:0]        op_rd,
  output logic                     op_wr,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  output logic [15:0]              stall_cnt
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_W-1:0] op_rd_q, op_rd_d;
  logic              op_wr_q, op_wr_d;
  logic [15:0]       stall_q, stall_d;
  logic              fwd1, fwd2, hazard, accept, wb_commit, rs1_zero, rs2_zero, rd_zero;

  assign rs1_zero  = R0_ZERO && (iss_rs1 == '0);
  assign rs2_zero  = R0_ZERO && (iss_rs2 == '0);
  assign rd_zero   = R0_ZERO && (iss_rd == '0);
  assign wb_commit = wb_valid && !(R0_ZERO && (wb_rd == '0));

`ifdef BYPASS_EN
  // A writeback landing this cycle satisfies a pending source without waiting for the commit.
  assign fwd1 = wb_valid && (wb_rd == iss_rs1) && (iss_rs1 != '0);
  assign fwd2 = wb_valid && (wb_rd == iss_rs2) && (iss_rs2 != '0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign hazard = (busy_q[iss_rs1] && !fwd1) || (busy_q[iss_rs2] && !fwd2) ||
                  (iss_wr && busy_q[iss_rd]);
  assign iss_ready = (!op_valid_q || op_ready) && !hazard;
  assign accept    = iss_valid && iss_ready;

  assign read_add_1 = iss_rs1;
  assign read_add_2 = iss_rs2;
  assign wr_reg_add = wb_rd;
  assign wr_data    = wb_data;
  assign wr_en      = wb_commit && rst;

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_rd     = op_rd_q;
  assign op_wr     = op_wr_q;
  assign busy_mask = busy_q;
  assign stall_cnt = stall_q;

  always_comb begin
    busy_d     = busy_q;
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    stall_d    = stall_q;

    // Clear before set so an accept that marks the same register wins.
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && iss_wr && !rd_zero) busy_d[iss_rd] = 1'b1;

    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = rs1_zero ? '0 : (fwd1 ? wb_data : read_data_1);
      op_b_d     = rs2_zero ? '0 : (fwd2 ? wb_data : read_data_2);
      op_rd_d    = iss_rd;
      op_wr_d    = iss_wr;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end

    if (iss_valid && hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_wr_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_wr_q    <= op_wr_d;
      stall_q    <= stall_d;
    end
  end
endmodule
